sd_read_ctrl: RTL

SD_READ_CTRL -- requirements
Module: sd_read_ctrl

---
 rtl/sd_read_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/sd_read_ctrl.sv
// SD card SPI-mode single-block reader: runs CMD0/CMD16 init once, then CMD17.
// It streams the block as 24-bit pixels, MSB-first, through an external SPI byte engine.
module sd_read_ctrl #(
  parameter int BLOCK_LEN   = 512,
  parameter int DUMMY_BYTES = 10,
  parameter int RESP_POLL   = 8,
  parameter int TOKEN_POLL  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] block_addr,
  output logic        cs,
  output logic        spi_start,
  output logic [7:0]  spi_tx,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx,
  output logic        pix_valid,
  output logic [23:0] pix_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int M1   = (DUMMY_BYTES > RESP_POLL) ? DUMMY_BYTES : RESP_POLL;
  localparam int M2   = (M1 > TOKEN_POLL) ? M1 : TOKEN_POLL;
  localparam int CMAX = (M2 > 6) ? M2 : 6;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int DW   = $clog2(BLOCK_LEN + 1);

  typedef enum logic [3:0] {
    IDLE, INIT_CLK, CMD_SEND, R1_POLL, TOKEN_POLL_S, DATA, CRC, TRAIL, FINISH
  } state_t;
  typedef enum logic [1:0] {CMD0, CMD16, CMD17} cmd_t;

  state_t        state, state_n;
  cmd_t          cmd, cmd_n;
  logic          init_flag, init_n;
  logic [31:0]   addr_q, addr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [1:0]    phase, phase_n;
  logic [15:0]   acc, acc_n;
  logic          pending, pending_n;
  logic          pix_valid_n, error_n;
  logic [23:0]   pix_data_n;
  logic          byte_done, abort;
  logic [5:0]    cmd_idx;
  logic [31:0]   arg;
  logic [7:0]    crc, r1_exp;
  logic [47:0]   frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd       <= CMD0;
      init_flag <= 1'b0;
      addr_q    <= '0;
      cnt       <= '0;
      dcnt      <= '0;
      phase     <= '0;
      acc       <= '0;
      pending   <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      error     <= 1'b0;
    end else begin
      state     <= state_n;
      cmd       <= cmd_n;
      init_flag <= init_n;
      addr_q    <= addr_n;
      cnt       <= cnt_n;
      dcnt      <= dcnt_n;
      phase     <= phase_n;
      acc       <= acc_n;
      pending   <= pending_n;
      pix_valid <= pix_valid_n;
      pix_data  <= pix_data_n;
      error     <= error_n;
    end
  end

  always_comb begin
    state_n     = state;
    cmd_n       = cmd;
    init_n      = init_flag;
    addr_n      = addr_q;
    cnt_n       = cnt;
    dcnt_n      = dcnt;
    phase_n     = phase;
    acc_n       = acc;
    pending_n   = pending;
    pix_valid_n = 1'b0;
    pix_data_n  = pix_data;
    error_n     = 1'b0;
    abort       = 1'b0;
    spi_start   = 1'b0;
    spi_tx      = 8'hFF;
    byte_done   = spi_done && pending;

    case (cmd)
      CMD0:    begin cmd_idx = 6'd0;  arg = 32'd0;          crc = 8'h95; r1_exp = 8'h01; end
      CMD16:   begin cmd_idx = 6'd16; arg = 32'(BLOCK_LEN); crc = 8'h01; r1_exp = 8'h00; end
      default: begin cmd_idx = 6'd17; arg = addr_q;         crc = 8'h01; r1_exp = 8'h00; end
    endcase
    frame = {2'b01, cmd_idx, arg, crc};

    cs   = !(state inside {CMD_SEND, R1_POLL, TOKEN_POLL_S, DATA, CRC});
    busy = (state != IDLE) && (state != FINISH);
    done = (state == FINISH);

    if (state == CMD_SEND) begin
      case (cnt[2:0])
        3'd0:    spi_tx = frame[47:40];
        3'd1:    spi_tx = frame[39:32];
        3'd2:    spi_tx = frame[31:24];
        3'd3:    spi_tx = frame[23:16];
        3'd4:    spi_tx = frame[15:8];
        default: spi_tx = frame[7:0];
      endcase
    end

    // Single outstanding transfer: relaunch only once the previous done has been consumed.
    if (busy && !pending) begin
      spi_start = 1'b1;
      pending_n = 1'b1;
    end
    if (byte_done) pending_n = 1'b0;

    case (state)
      IDLE: if (start) begin
        addr_n = block_addr;
        cnt_n  = '0;
        if (init_flag) begin
          state_n = CMD_SEND;
          cmd_n   = CMD17;
        end else begin
          state_n = INIT_CLK;
        end
      end
      INIT_CLK: if (byte_done) begin
        if (cnt == CW'(DUMMY_BYTES - 1)) begin
          state_n = CMD_SEND;
          cmd_n   = CMD0;
          cnt_n   = '0;
        end else cnt_n = cnt + 1'b1;
      end
      CMD_SEND: if (byte_done) begin
        if (cnt == CW'(5)) begin
          state_n = R1_POLL;
          cnt_n   = '0;
        end else cnt_n = cnt + 1'b1;
      end
      R1_POLL: if (byte_done) begin
        if (!spi_rx[7]) begin
          cnt_n = '0;
          if (spi_rx != r1_exp) abort = 1'b1;
          else if (cmd == CMD0) begin
            state_n = CMD_SEND;
            cmd_n   = CMD16;
          end else if (cmd == CMD16) begin
            state_n = CMD_SEND;
            cmd_n   = CMD17;
            init_n  = 1'b1;
          end else state_n = TOKEN_POLL_S;
        end else if (cnt == CW'(RESP_POLL - 1)) abort = 1'b1;
        else cnt_n = cnt + 1'b1;
      end
      TOKEN_POLL_S: if (byte_done) begin
        if (spi_rx == 8'hFE) begin
          state_n = DATA;
          cnt_n   = '0;
          dcnt_n  = '0;
          phase_n = '0;
        end else if (spi_rx != 8'hFF || cnt == CW'(TOKEN_POLL - 1)) abort = 1'b1;
        else cnt_n = cnt + 1'b1;
      end
      DATA: if (byte_done) begin
        acc_n = {acc[7:0], spi_rx};
        if (phase == 2'd2) begin
          phase_n     = '0;
          pix_valid_n = 1'b1;
          pix_data_n  = {acc, spi_rx};
        end else phase_n = phase + 1'b1;
        // A partial trailing pixel is simply never emitted.
        if (dcnt == DW'(BLOCK_LEN - 1)) begin
          state_n = CRC;
          cnt_n   = '0;
        end else dcnt_n = dcnt + 1'b1;
      end
      CRC: if (byte_done) begin
        if (cnt == CW'(1)) begin
          state_n = TRAIL;
          cnt_n   = '0;
        end else cnt_n = cnt + 1'b1;
      end
      TRAIL:   if (byte_done) state_n = FINISH;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (abort) begin
      state_n = IDLE;
      error_n = 1'b1;
      init_n  = 1'b0;
      cnt_n   = '0;
      dcnt_n  = '0;
    end
  end

endmodule
